// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a valid/ready load handshake and gapless streaming.
// Define PISO_PARITY_EN to append an even-parity bit to every word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             frame,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             sdo_q, sdo_d;
  logic             frame_q, frame_d;
  logic             final_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // The final bit cycle doubles as a load slot so back-to-back words leave no gap.
`ifdef PISO_PARITY_EN
  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == LAST);
`endif

  assign load_ready = (state_q == IDLE) || final_bit;
  assign accept     = load_valid && load_ready;
  assign done       = final_bit;
  assign sdo        = sdo_q;
  assign frame      = frame_q;

  assign first_bit = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = (MSB_FIRST != 0) ? shift_q[WIDTH-2]   : shift_q[1];
  assign shifted   = (MSB_FIRST != 0) ? (shift_q << 1)     : (shift_q >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sdo_d   = 1'b0;
    frame_d = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = shifted;
          sdo_d   = next_bit;
          frame_d = 1'b1;
        end
`ifdef PISO_PARITY_EN
        else begin
          state_d = PARITY;
          cnt_d   = '0;
          sdo_d   = par_q;
          frame_d = 1'b1;
        end
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: ;
`endif
      default: state_d = IDLE;
    endcase

    // A new word overrides whatever the current state would have done next.
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      shift_d = load_data;
      sdo_d   = first_bit;
      frame_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d   = ^load_data;
`endif
    end else if (final_bit) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sdo_q   <= sdo_d;
      frame_q <= frame_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance share the
// same load stimulus; a per-bit queue model predicts sdo/frame/done/load_ready every cycle.
module tb_piso_serializer;

  localparam int W = 8;

  typedef struct {
    logic b;
    logic last;
  } bit_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         ready_m, sdo_m, frame_m, done_m;
  logic         ready_l, sdo_l, frame_l, done_l;

  bit_t qm[$];
  bit_t ql[$];
  logic acc_evt;
  int   checks;
  int   errors;
  int   done_seen;
  int   done_exp;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .sdo(sdo_m), .frame(frame_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .sdo(sdo_l), .frame(frame_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue head is the bit currently on sdo; each edge retires it and may load a word.
  always @(posedge clk) begin
    logic rdy;
    logic par;
    acc_evt = 1'b0;
    if (!rst_n) begin
      qm.delete();
      ql.delete();
    end else begin
      rdy = (qm.size() <= 1);
      if (qm.size() > 0) begin
        qm.delete(0);
        ql.delete(0);
      end
      if (load_valid && rdy) begin
        acc_evt = 1'b1;
        par = ^load_data;
        for (int k = 0; k < W; k++) begin
`ifdef PISO_PARITY_EN
          qm.push_back('{b: load_data[W-1-k], last: 1'b0});
          ql.push_back('{b: load_data[k], last: 1'b0});
`else
          qm.push_back('{b: load_data[W-1-k], last: (k == W-1)});
          ql.push_back('{b: load_data[k], last: (k == W-1)});
`endif
        end
`ifdef PISO_PARITY_EN
        qm.push_back('{b: par, last: 1'b1});
        ql.push_back('{b: par, last: 1'b1});
`endif
      end
    end
  end

  always @(negedge rst_n) begin
    qm.delete();
    ql.delete();
  end

  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = (qm.size() <= 1);
    checkOutput("ready_msb", ready_m, exp_rdy);
    checkOutput("ready_lsb", ready_l, exp_rdy);
    if (done_m) done_seen++;
    if (qm.size() > 0) begin
      if (qm[0].last) done_exp++;
      checkOutput("sdo_msb", sdo_m, qm[0].b);
      checkOutput("sdo_lsb", sdo_l, ql[0].b);
      checkOutput("frame_msb", frame_m, 1);
      checkOutput("frame_lsb", frame_l, 1);
      checkOutput("done_msb", done_m, qm[0].last);
      checkOutput("done_lsb", done_l, ql[0].last);
    end else begin
      checkOutput("idle_sdo_msb", sdo_m, 0);
      checkOutput("idle_sdo_lsb", sdo_l, 0);
      checkOutput("idle_frame_msb", frame_m, 0);
      checkOutput("idle_frame_lsb", frame_l, 0);
      checkOutput("idle_done_msb", done_m, 0);
      checkOutput("idle_done_lsb", done_l, 0);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    load_data  = d;
    load_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (acc_evt) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", got, 1);
    load_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (qm.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", idle, 1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    done_seen  = 0;
    done_exp   = 0;
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    #2;
    checkOutput("rst_sdo", sdo_m, 0);
    checkOutput("rst_frame", frame_m, 0);
    checkOutput("rst_done", done_m, 0);
    checkOutput("rst_ready", ready_m, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_no_accept_frame", frame_m, 0);
    load_valid = 1'b0;
    rst_n      = 1'b1;

    // Basic words and bit order
    applyStimulus(8'hA5);
    waitIdle();
    applyStimulus(8'h01);
    waitIdle();

    // Streaming: second word offered as soon as the first is taken
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    waitIdle();

    // Backpressure: offer a word mid-flight
    applyStimulus(8'hA5);
    repeat (2) @(negedge clk);
    applyStimulus(8'h3C);
    waitIdle();

    // Asynchronous reset mid-word
    applyStimulus(8'hA5);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_sdo_msb", sdo_m, 0);
    checkOutput("midrst_frame_msb", frame_m, 0);
    checkOutput("midrst_done_msb", done_m, 0);
    checkOutput("midrst_frame_lsb", frame_l, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h81);
    waitIdle();

`ifdef PISO_PARITY_EN
    applyStimulus(8'h07);
    waitIdle();
`endif

    // Random words with random idle gaps
    for (int i = 0; i < 8; i++) begin
      applyStimulus(W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle();
    @(negedge clk);
    checkOutput("done_count", done_seen, done_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that turns a WIDTH-bit word into a bit stream, one bit per rising edge of `clk`. It is the transmitting end of the team's flip-flop based serial capture path: `sdo` drives the `D` input of a downstream edge-triggered flip-flop or shift-register receiver, and `frame` marks the valid bits. A valid/ready load handshake supplies words, and back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `load_data`  input  WIDTH  word to transmit; sampled on handshake.
- `load_valid`  input  1  `load_data` is valid.
- `load_ready`  output  1  block accepts a word this cycle.
- `sdo`  output  1  serial data out; registered.
- `frame`  output  1  high while `sdo` carries a data bit or a parity bit; registered.
- `done`  output  1  high during the cycle the last bit of a word is on `sdo`.

## Operation
- States:
  - IDLE: `sdo`=0, `frame`=0.
  - SHIFT: one bit per cycle.
  - PARITY: only when `PISO_PARITY_EN` is defined.
- Handshake: a word is accepted on a rising edge where `load_valid`=1 and `load_ready`=1. The word is copied into the internal shift register. `load_data` is not used after that edge.
- `load_ready` = 1 in IDLE and in the final bit cycle of a word (the last SHIFT cycle, or the PARITY cycle when parity is enabled). It is 0 otherwise.
- IDLE -> SHIFT on accept.
- SHIFT: the bit counter runs 0..WIDTH-1. At count WIDTH-1 the next state is:
  - PARITY, when parity is enabled;
  - SHIFT with count 0, if a new word is accepted in the same cycle;
  - IDLE otherwise.
- PARITY -> SHIFT on accept, otherwise PARITY -> IDLE.
- Bit counter width is $clog2(WIDTH). It resets to 0 at the start of every word.
- `load_valid` while `load_ready`=0: no effect. The source must hold the word, and the block takes it when `load_ready` rises.
- `rst_n` low at any time, including mid-word: immediately forces IDLE, `sdo`=0, `frame`=0, `done`=0, counter=0. The partial word is discarded and no `done` is produced.
- Handshakes are ignored while `rst_n` is low.

## Timing
- Reset values:
  - `sdo`=0, `frame`=0, `done`=0.
  - `load_ready`=1 (IDLE decode), but no accept occurs until `rst_n` is high at a rising edge.
- Latency: word accepted at edge N. First bit appears on `sdo`, with `frame`=1, after edge N and stays for cycle N+1. Bit k appears after edge N+k.
- Frame length: WIDTH cycles, or WIDTH+1 cycles with parity.
- `done` is a combinational decode of the registered state. It is valid after the same edge as the last bit and high for exactly one cycle per word.
- Back-to-back: an accept in the final bit cycle makes the new word's first bit follow the last bit with no gap. `frame` stays 1 and `done` still pulses once per word.

## Configuration
- `PISO_PARITY_EN` defined: one extra bit follows each word, with `frame`=1. The bit is even parity, the XOR of all WIDTH data bits. `done` and `load_ready` move to the parity cycle.
- `PISO_PARITY_EN` undefined: there is no PARITY state and no parity logic. The frame is exactly WIDTH cycles.

## Test plan
- Basic word: WIDTH=8, MSB_FIRST=1, load 0xA5 at edge 0.
  - `sdo` = 1,0,1,0,0,1,0,1 over cycles 1..8, with `frame`=1 on those cycles.
  - `done`=1 on cycle 8 only.
  - `sdo`=0 and `frame`=0 from cycle 9.
- Bit order: MSB_FIRST=0, load 0x01 -> `sdo` = 1,0,0,0,0,0,0,0 over cycles 1..8.
- Streaming: load 0xFF, then hold `load_valid`=1 with 0x00.
  - Second word accepted on cycle 8.
  - `frame`=1 continuously for cycles 1..16; `sdo` is eight 1s then eight 0s.
  - `done` pulses on cycles 8 and 16.
- Backpressure: assert `load_valid` with 0x3C on cycle 3 of an in-flight word.
  - `load_ready`=0 until cycle 8, then the word is accepted.
  - No data corruption of either word.
- Reset mid-word: drop `rst_n` asynchronously on cycle 4 of 0xA5.
  - `sdo`, `frame` and `done` go to 0 immediately, with no `done` pulse.
  - After release, a load of 0x81 transmits cleanly as 1,0,0,0,0,0,0,1.
- Parity (`PISO_PARITY_EN`):
  - 0xA5 -> 9-bit frame ending in parity 0, with `done` on cycle 9.
  - 0x07 -> parity bit 1.
